datapath: RTL and testbench

//  32-bit single-bus CPU datapath: 16 GPRs, PC, HI, LO, Y, 64-bit Z, MAR, MDR, InPort, ALU.
//  One register drives the shared bus per cycle; any subset of registers loads from it on the clock edge.
//  The external control unit or testbench sequences the control strobes.

---
 rtl/datapath_pkg.sv | 37 +++
 rtl/datapath_alu.sv | 62 ++++++
 rtl/datapath.sv | 151 +++++++++++++++
 tb/tb_datapath.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus CPU datapath.
//   DataWidth  : width of every architectural register and of the bus
//   OpWidth    : width of the ALU opcode
//   ADD..NOT   : ALU opcode encodings
//   Src*       : bus source indices produced by the one-hot encoder
package datapath_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned OpWidth   = 5;
    localparam int unsigned NumGpr    = 16;

    localparam logic [OpWidth-1:0] ADD  = 5'b00011;
    localparam logic [OpWidth-1:0] SUB  = 5'b00100;
    localparam logic [OpWidth-1:0] SHR  = 5'b00101;
    localparam logic [OpWidth-1:0] SHRA = 5'b00110;
    localparam logic [OpWidth-1:0] SHL  = 5'b00111;
    localparam logic [OpWidth-1:0] ROR  = 5'b01000;
    localparam logic [OpWidth-1:0] ROL  = 5'b01001;
    localparam logic [OpWidth-1:0] AND  = 5'b01010;
    localparam logic [OpWidth-1:0] OR   = 5'b01011;
    localparam logic [OpWidth-1:0] MUL  = 5'b01111;
    localparam logic [OpWidth-1:0] DIV  = 5'b10000;
    localparam logic [OpWidth-1:0] NEG  = 5'b10001;
    localparam logic [OpWidth-1:0] NOT  = 5'b10010;

    // Bus sources in priority order: a lower index wins when several strobes are high.
    localparam int unsigned NumBusSrc = 23;
    localparam int unsigned SelWidth  = 5;
    localparam logic [SelWidth-1:0] SrcHi     = 5'd16;
    localparam logic [SelWidth-1:0] SrcLo     = 5'd17;
    localparam logic [SelWidth-1:0] SrcZHigh  = 5'd18;
    localparam logic [SelWidth-1:0] SrcZLow   = 5'd19;
    localparam logic [SelWidth-1:0] SrcPc     = 5'd20;
    localparam logic [SelWidth-1:0] SrcMdr    = 5'd21;
    localparam logic [SelWidth-1:0] SrcInPort = 5'd22;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath.
//   i_a      : operand A (Y register)
//   i_b      : operand B (shared bus)
//   i_opcode : operation select
//   o_result : 64-bit result {hi, lo}; hi is zero except for mul and div
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DataWidth-1:0]   i_a,
    input  logic [DataWidth-1:0]   i_b,
    input  logic [OpWidth-1:0]     i_opcode,
    output logic [2*DataWidth-1:0] o_result
);

    logic [4:0]             w_sh;
    logic [2*DataWidth-1:0] w_prod;
    logic                   w_div_ovf;
    logic [DataWidth-1:0]   w_quot;
    logic [DataWidth-1:0]   w_rem;

    always_comb begin
        w_sh   = i_b[4:0];
        w_prod = $signed({{DataWidth{i_a[DataWidth-1]}}, i_a})
               * $signed({{DataWidth{i_b[DataWidth-1]}}, i_b});
        // Most-negative / -1 overflows a 32-bit quotient; pin it to the wrapped value.
        w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
        w_quot    = '0;
        w_rem     = '0;
        if ((i_b != '0) && !w_div_ovf) begin
            w_quot = $signed(i_a) / $signed(i_b);
            w_rem  = $signed(i_a) % $signed(i_b);
        end else if (w_div_ovf) begin
            w_quot = 32'h8000_0000;
        end

        o_result = '0;
        case (i_opcode)
            ADD:  o_result[DataWidth-1:0] = i_a + i_b;
            SUB:  o_result[DataWidth-1:0] = i_a - i_b;
            SHR:  o_result[DataWidth-1:0] = i_a >> w_sh;
            SHRA: o_result[DataWidth-1:0] = $signed(i_a) >>> w_sh;
            SHL:  o_result[DataWidth-1:0] = i_a << w_sh;
            // Shift by 32 yields 0, so a zero rotate amount leaves A unchanged.
            ROR:  o_result[DataWidth-1:0] = (i_a >> w_sh) | (i_a << (6'd32 - {1'b0, w_sh}));
            ROL:  o_result[DataWidth-1:0] = (i_a << w_sh) | (i_a >> (6'd32 - {1'b0, w_sh}));
            AND:  o_result[DataWidth-1:0] = i_a & i_b;
            OR:   o_result[DataWidth-1:0] = i_a | i_b;
            MUL:  o_result = w_prod;
            DIV: begin
                if (i_b == '0) begin
                    o_result = {i_a, 32'hFFFF_FFFF};
                end else begin
                    o_result = {w_rem, w_quot};
                end
            end
            NEG:  o_result[DataWidth-1:0] = 32'd0 - i_b;
            NOT:  o_result[DataWidth-1:0] = ~i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// 32-bit single-bus CPU datapath.
//   clock, clear            : rising-edge clock, asynchronous active-high reset
//   R0in..R15in, PCin, HIin, LOin, Yin, MARin, InPortIn : load register from bus
//   Zin                     : load 64-bit Z from the ALU
//   MDRin, read             : load MDR from Mdatain (read=1) or bus (read=0)
//   incPC                   : PC <= PC + 1 unless PCin is also high
//   opcode                  : ALU operation
//   Mdatain                 : memory read data
//   R0out..R15out, HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut : bus drive
//   BusMuxOut               : current bus value
module datapath
    import datapath_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic                 R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic                 PCin,
    input  logic                 HIin,
    input  logic                 LOin,
    input  logic                 Yin,
    input  logic                 MARin,
    input  logic                 InPortIn,
    input  logic                 Zin,
    input  logic                 MDRin,
    input  logic                 read,
    input  logic                 incPC,
    input  logic [OpWidth-1:0]   opcode,
    input  logic [DataWidth-1:0] Mdatain,
    input  logic                 R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic                 R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic                 PCout,
    input  logic                 HIout,
    input  logic                 LOout,
    input  logic                 ZHighOut,
    input  logic                 ZLowOut,
    input  logic                 MDRout,
    input  logic                 InPortOut,
    output logic [DataWidth-1:0] BusMuxOut
);

    logic [DataWidth-1:0]   r_gpr [NumGpr];
    logic [DataWidth-1:0]   r_pc;
    logic [DataWidth-1:0]   r_hi;
    logic [DataWidth-1:0]   r_lo;
    logic [DataWidth-1:0]   r_y;
    logic [2*DataWidth-1:0] r_z;
    logic [DataWidth-1:0]   r_mar;
    logic [DataWidth-1:0]   r_mdr;
    logic [DataWidth-1:0]   r_inport;

    logic [NumGpr-1:0]      w_gpr_in;
    logic [NumBusSrc-1:0]   w_out_strobe;
    logic [SelWidth-1:0]    w_sel;
    logic                   w_bus_valid;
    logic [DataWidth-1:0]   w_bus;
    logic [2*DataWidth-1:0] w_alu_result;
    logic                   w_unused_mar;

    assign w_gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                       R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    // Bit index equals bus priority: bit 0 (R0out) is the strongest driver.
    assign w_out_strobe = {InPortOut, MDRout, PCout, ZLowOut, ZHighOut, LOout, HIout,
                           R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                           R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Priority encoder: scanning downward leaves the lowest set index in w_sel.
    always_comb begin
        w_bus_valid = |w_out_strobe;
        w_sel       = '0;
        for (int i = int'(NumBusSrc) - 1; i >= 0; i--) begin
            if (w_out_strobe[i]) begin
                w_sel = SelWidth'(i);
            end
        end
    end

    always_comb begin
        w_bus = '0;
        if (w_bus_valid) begin
            if (w_sel < SelWidth'(NumGpr)) begin
                w_bus = r_gpr[w_sel[3:0]];
            end else begin
                case (w_sel)
                    SrcHi:     w_bus = r_hi;
                    SrcLo:     w_bus = r_lo;
                    SrcZHigh:  w_bus = r_z[2*DataWidth-1:DataWidth];
                    SrcZLow:   w_bus = r_z[DataWidth-1:0];
                    SrcPc:     w_bus = r_pc;
                    SrcMdr:    w_bus = r_mdr;
                    SrcInPort: w_bus = r_inport;
                    default:   w_bus = '0;
                endcase
            end
        end
    end

    assign BusMuxOut = w_bus;

    datapath_alu u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_opcode (opcode),
        .o_result (w_alu_result)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < int'(NumGpr); i++) begin
                r_gpr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumGpr); i++) begin
                if (w_gpr_in[i]) begin
                    r_gpr[i] <= w_bus;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_pc     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_inport <= '0;
        end else begin
            if (PCin) begin
                r_pc <= w_bus;
            end else if (incPC) begin
                r_pc <= r_pc + 32'd1;
            end
            if (HIin)     r_hi     <= w_bus;
            if (LOin)     r_lo     <= w_bus;
            if (Yin)      r_y      <= w_bus;
            if (Zin)      r_z      <= w_alu_result;
            if (MARin)    r_mar    <= w_bus;
            if (InPortIn) r_inport <= w_bus;
            if (MDRin)    r_mdr    <= read ? Mdatain : w_bus;
        end
    end

    // MAR drives the memory address bus outside this block; nothing here reads it.
    assign w_unused_mar = ^r_mar;

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: strobes are sequenced cycle by cycle and every
// register value is observed on BusMuxOut through a small expected-value queue.
module tb_datapath;
    import datapath_pkg::*;

    // Load-strobe bit positions within ins (0..15 are the GPRs).
    localparam int InHi = 16, InLo = 17, InY = 18, InPc = 19;
    localparam int InMar = 20, InPort = 21, InZ = 22, InMdr = 23;
    // Drive-strobe bit positions within outs (0..15 are the GPRs).
    localparam int OutHi = 16, OutLo = 17, OutZh = 18, OutZl = 19;
    localparam int OutPc = 20, OutMdr = 21, OutPort = 22;

    logic        clock;
    logic        clear;
    logic [23:0] ins;
    logic [22:0] outs;
    logic        read;
    logic        incPC;
    logic [4:0]  opcode;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    datapath dut (
        .clock     (clock),
        .clear     (clear),
        .R0in      (ins[0]),  .R1in  (ins[1]),  .R2in  (ins[2]),  .R3in  (ins[3]),
        .R4in      (ins[4]),  .R5in  (ins[5]),  .R6in  (ins[6]),  .R7in  (ins[7]),
        .R8in      (ins[8]),  .R9in  (ins[9]),  .R10in (ins[10]), .R11in (ins[11]),
        .R12in     (ins[12]), .R13in (ins[13]), .R14in (ins[14]), .R15in (ins[15]),
        .PCin      (ins[InPc]),
        .HIin      (ins[InHi]),
        .LOin      (ins[InLo]),
        .Yin       (ins[InY]),
        .MARin     (ins[InMar]),
        .InPortIn  (ins[InPort]),
        .Zin       (ins[InZ]),
        .MDRin     (ins[InMdr]),
        .read      (read),
        .incPC     (incPC),
        .opcode    (opcode),
        .Mdatain   (Mdatain),
        .R0out     (outs[0]),  .R1out  (outs[1]),  .R2out  (outs[2]),  .R3out  (outs[3]),
        .R4out     (outs[4]),  .R5out  (outs[5]),  .R6out  (outs[6]),  .R7out  (outs[7]),
        .R8out     (outs[8]),  .R9out  (outs[9]),  .R10out (outs[10]), .R11out (outs[11]),
        .R12out    (outs[12]), .R13out (outs[13]), .R14out (outs[14]), .R15out (outs[15]),
        .PCout     (outs[OutPc]),
        .HIout     (outs[OutHi]),
        .LOout     (outs[OutLo]),
        .ZHighOut  (outs[OutZh]),
        .ZLowOut   (outs[OutZl]),
        .MDRout    (outs[OutMdr]),
        .InPortOut (outs[OutPort]),
        .BusMuxOut (BusMuxOut)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] src(input int idx);
        logic [22:0] m;
        m = '0;
        if (idx >= 0) m[idx] = 1'b1;
        return m;
    endfunction

    function automatic logic [23:0] dst(input int idx);
        logic [23:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // One clock edge with the given strobes; everything is released just after the edge.
    task automatic cycle(input logic [22:0] o, input logic [23:0] i);
        outs = o;
        ins  = i;
        @(posedge clock);
        #1;
        outs   = '0;
        ins    = '0;
        read   = 1'b0;
        incPC  = 1'b0;
        opcode = '0;
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        Mdatain = v;
        read    = 1'b1;
        cycle('0, dst(InMdr));
        cycle(src(OutMdr), dst(idx));
    endtask

    task automatic alu(input logic [4:0] op, input int b_src);
        opcode = op;
        cycle(src(b_src), dst(InZ));
    endtask

    // Queue the expectation, drive the bus strobes, then retire it against the DUT.
    task automatic expect_bus(input string tag, input logic [22:0] mask, input logic [31:0] v);
        exp_t e;
        sb.push_back('{tag: tag, val: v});
        outs = mask;
        #1;
        e = sb.pop_front();
        check_eq(e.tag, BusMuxOut, e.val);
        outs = '0;
    endtask

    task automatic expect_z(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        expect_bus({tag, "_lo"}, src(OutZl), lo);
        expect_bus({tag, "_hi"}, src(OutZh), hi);
    endtask

    initial begin
        clear   = 1'b1;
        ins     = '0;
        outs    = '0;
        read    = 1'b0;
        incPC   = 1'b0;
        opcode  = '0;
        Mdatain = '0;
        #12;
        clear = 1'b0;
        #2;

        for (int s = 0; s < 23; s++) begin
            expect_bus($sformatf("rst_src%0d", s), src(s), 32'h0);
        end
        expect_bus("rst_nobus", '0, 32'h0);

        // Asynchronous clear in the middle of work.
        load_reg(5, 32'd7);
        cycle(src(5), dst(InY) | dst(InHi));
        expect_bus("pre_clr_r5", src(5), 32'd7);
        clear = 1'b1;
        #1;
        expect_bus("clr_r5", src(5), 32'h0);
        expect_bus("clr_hi", src(OutHi), 32'h0);
        expect_bus("clr_mdr", src(OutMdr), 32'h0);
        expect_bus("clr_bus", '0, 32'h0);
        clear = 1'b0;
        #1;
        alu(ADD, -1);
        expect_bus("clr_y", src(OutZl), 32'h0);

        // Load path through MDR.
        load_reg(4, 32'd30);
        load_reg(3, 32'd25);
        load_reg(7, 32'd10);
        expect_bus("ld_r4", src(4), 32'd30);
        expect_bus("ld_r3", src(3), 32'd25);
        expect_bus("ld_r7", src(7), 32'd10);

        // Subtract: R7 <= R4 - R3.
        cycle(src(4), dst(InY));
        alu(SUB, 3);
        cycle(src(OutZl), dst(7));
        expect_bus("sub_pos", src(7), 32'd5);
        load_reg(4, 32'd25);
        load_reg(3, 32'd30);
        cycle(src(4), dst(InY));
        alu(SUB, 3);
        cycle(src(OutZl), dst(7));
        expect_bus("sub_neg", src(7), 32'hFFFF_FFFB);

        // Multiply / divide with Y = -6, B = 4.
        load_reg(1, 32'hFFFF_FFFA);
        load_reg(2, 32'd4);
        cycle(src(1), dst(InY));
        alu(MUL, 2);
        expect_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFE8);
        cycle(src(OutZh), dst(InHi));
        expect_bus("mul_hi_reg", src(OutHi), 32'hFFFF_FFFF);
        alu(DIV, 2);
        expect_z("div", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
        alu(DIV, 0);
        expect_z("div0", 32'hFFFF_FFFA, 32'hFFFF_FFFF);
        alu(NEG, 2);
        expect_z("neg", 32'h0, 32'hFFFF_FFFC);
        alu(NOT, 2);
        expect_bus("not", src(OutZl), 32'hFFFF_FFFB);

        // Shifts and logic with Y = 0x80000001.
        load_reg(8, 32'h8000_0001);
        load_reg(9, 32'd1);
        cycle(src(8), dst(InY));
        alu(SHR, 9);
        expect_bus("shr", src(OutZl), 32'h4000_0000);
        alu(SHRA, 9);
        expect_bus("shra", src(OutZl), 32'hC000_0000);
        alu(ROR, 9);
        expect_bus("ror", src(OutZl), 32'hC000_0000);
        alu(ROL, 9);
        expect_bus("rol", src(OutZl), 32'h0000_0003);
        alu(SHL, 9);
        expect_bus("shl", src(OutZl), 32'h0000_0002);
        alu(SHRA, 0);
        expect_bus("shra_by0", src(OutZl), 32'h8000_0001);
        alu(ROR, 0);
        expect_bus("ror_by0", src(OutZl), 32'h8000_0001);
        alu(ADD, 9);
        expect_z("add", 32'h0, 32'h8000_0002);
        alu(AND, 9);
        expect_bus("and", src(OutZl), 32'h0000_0001);
        alu(OR, 2);
        expect_bus("or", src(OutZl), 32'h8000_0005);
        alu(5'b11111, 9);
        expect_z("bad_op", 32'h0, 32'h0);

        // PC increment and PCin priority.
        expect_bus("pc_init", src(OutPc), 32'h0);
        incPC = 1'b1;
        cycle('0, '0);
        expect_bus("pc_inc", src(OutPc), 32'd1);
        load_reg(10, 32'd9);
        incPC = 1'b1;
        cycle(src(10), dst(InPc));
        expect_bus("pc_load_prio", src(OutPc), 32'd9);
        load_reg(13, 32'hFFFF_FFFF);
        cycle(src(13), dst(InPc));
        incPC = 1'b1;
        cycle('0, '0);
        expect_bus("pc_wrap", src(OutPc), 32'h0);

        // Bus priority: R2 beats MDR (MDR currently holds 0xFFFFFFFF).
        expect_bus("prio_r2_mdr", src(2) | src(OutMdr), 32'd4);
        expect_bus("prio_hi_pc", src(OutHi) | src(OutPc), 32'hFFFF_FFFF);

        // MDR from the bus when read is low.
        Mdatain = 32'h0000_0555;
        cycle(src(9), dst(InMdr));
        expect_bus("mdr_from_bus", src(OutMdr), 32'd1);

        // Remaining bus-loaded registers and a multi-destination load.
        cycle(src(3), dst(InPort));
        expect_bus("inport", src(OutPort), 32'd30);
        cycle(src(8), dst(InLo));
        expect_bus("lo", src(OutLo), 32'h8000_0001);
        cycle(src(9), dst(11) | dst(12));
        cycle(src(9), dst(11) | dst(12));
        expect_bus("multi_r11", src(11), 32'd1);
        expect_bus("multi_r12", src(12), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
